// File: rtl/wb_vmon_responder.sv
// Wishbone register window bridging a bus master to a host-side pair of FWFT FIFOs.
// Latency: ACK/ERR registered one cycle after the hit edge; TX writes to a full FIFO wait in STALL.
// Backpressure: full t2h FIFO stalls the bus; h2t_ready drops while the h2t FIFO is full.

// Small FWFT FIFO: head visible on dout, wrapping pointers plus explicit occupancy count.
// Latency: a push is visible on dout the cycle after the pushing edge when the FIFO was empty.
// Backpressure: push ignored while full, pop ignored while empty; flush empties it at once.
module vmon_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [3:0]       cnt;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the count as it stood before the edge, so a push
    // into a full FIFO is refused even if a pop happens at the same edge.
    assign full    = (cnt == 4'(DEPTH));
    assign empty   = (cnt == 4'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy update; flush overrides any push/pop at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage write; contents need no reset since the count guards visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush && !rst_i) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// Wishbone slave with TX/RX/STATUS/CTRL registers in front of two host FIFOs.
// Latency: every resolved access answers with a single-cycle ACK or ERR one cycle after its edge.
// Backpressure: a TX write into a full t2h FIFO holds the bus in STALL until space or abandonment.
module wb_vmon_responder #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS       = 'h6000_1000,
    parameter int                       FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] ADR,
    input  logic [WB_DATA_WIDTH-1:0] DAT_W,
    output logic [WB_DATA_WIDTH-1:0] DAT_R,
    input  logic                     CYC,
    input  logic                     STB,
    input  logic                     WE,
    input  logic [3:0]               SEL,
    output logic                     ACK,
    output logic                     ERR,
    output logic                     t2h_valid,
    output logic [31:0]              t2h_data,
    input  logic                     t2h_ready,
    input  logic                     h2t_valid,
    input  logic [31:0]              h2t_data,
    output logic                     h2t_ready
);

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_RX     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Bus decode
    logic       req;
    logic       hit;
    logic [1:0] off;
    logic       full_word;
    logic       tx_wr;

    // FIFO side
    logic        t2h_push;
    logic        t2h_full;
    logic        t2h_empty;
    logic [3:0]  t2h_cnt;
    logic        h2t_pop;
    logic        h2t_full;
    logic        h2t_empty;
    logic [3:0]  h2t_cnt;
    logic [31:0] h2t_dout;
    logic        flush;

    // Registered response, next values
    logic                     ack_nx;
    logic                     err_nx;
    logic [WB_DATA_WIDTH-1:0] rdat_nx;
    logic [WB_DATA_WIDTH-1:0] status;

    // Byte lane within a word plays no part in register selection.
    logic unused_adr;
    assign unused_adr = ^ADR[1:0];

    assign req       = CYC & STB;
    assign hit       = req & (ADR[WB_ADDR_WIDTH-1:4] == ADDRESS[WB_ADDR_WIDTH-1:4]);
    assign off       = ADR[3:2];
    assign full_word = (SEL == 4'hF);
    assign tx_wr     = WE & full_word & (off == OFF_TX);

    assign status = {12'd0, t2h_cnt, 4'd0, h2t_cnt, 6'd0, t2h_full, ~h2t_empty};

    assign t2h_valid = ~t2h_empty;
    assign h2t_ready = ~h2t_full;

    vmon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_t2h_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (flush),
        .push  (t2h_push),
        .din   (DAT_W),
        .pop   (t2h_ready),
        .dout  (t2h_data),
        .count (t2h_cnt),
        .full  (t2h_full),
        .empty (t2h_empty)
    );

    vmon_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_h2t_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (flush),
        .push  (h2t_valid),
        .din   (h2t_data),
        .pop   (h2t_pop),
        .dout  (h2t_dout),
        .count (h2t_cnt),
        .full  (h2t_full),
        .empty (h2t_empty)
    );

    // State register; reset drops any in-flight access without answering it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: IDLE resolves hits, STALL waits for t2h space, RESP forces an idle gap.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    state_nx = (tx_wr && t2h_full) ? S_STALL : S_RESP;
                end
            end
            S_STALL: begin
                if (!req) begin
                    state_nx = S_IDLE;
                end else if (!t2h_full) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Access side effects and the response to register at this edge.
    always_comb begin
        t2h_push = 1'b0;
        h2t_pop  = 1'b0;
        flush    = 1'b0;
        ack_nx   = 1'b0;
        err_nx   = 1'b0;
        rdat_nx  = '0;
        case (state)
            S_IDLE: begin
                if (hit) begin
                    if (WE) begin
                        // Partial writes are rejected outright, whatever the offset.
                        if (!full_word) begin
                            err_nx = 1'b1;
                        end else begin
                            case (off)
                                OFF_TX: begin
                                    if (!t2h_full) begin
                                        t2h_push = 1'b1;
                                        ack_nx   = 1'b1;
                                    end
                                end
                                OFF_CTRL: begin
                                    flush  = DAT_W[0];
                                    ack_nx = 1'b1;
                                end
                                default: err_nx = 1'b1;
                            endcase
                        end
                    end else begin
                        ack_nx = 1'b1;
                        case (off)
                            OFF_RX: begin
                                // An empty RX read still completes, returning zero.
                                if (!h2t_empty) begin
                                    h2t_pop = 1'b1;
                                    rdat_nx = h2t_dout;
                                end
                            end
                            OFF_STATUS: rdat_nx = status;
                            default:    rdat_nx = '0;
                        endcase
                    end
                end
            end
            S_STALL: begin
                if (req && !t2h_full) begin
                    t2h_push = 1'b1;
                    ack_nx   = 1'b1;
                end
            end
            default: begin
                t2h_push = 1'b0;
            end
        endcase
    end

    // Response register: ACK/ERR pulse for one cycle, DAT_R only non-zero alongside ACK.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ACK   <= 1'b0;
            ERR   <= 1'b0;
            DAT_R <= '0;
        end else begin
            ACK   <= ack_nx;
            ERR   <= err_nx;
            DAT_R <= ack_nx ? rdat_nx : '0;
        end
    end

endmodule

// File: tb/tb_wb_vmon_responder.sv
// Randomised plus directed bench for wb_vmon_responder with a queue-based reference model.
// Latency: expected responses are queued at issue and consumed when ACK/ERR appears.
// Backpressure: host pops are used to release stalled TX writes.
module tb_wb_vmon_responder;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ADR = '0;
    logic [31:0] DAT_W = '0;
    logic [31:0] DAT_R;
    logic        CYC = 1'b0;
    logic        STB = 1'b0;
    logic        WE = 1'b0;
    logic [3:0]  SEL = 4'h0;
    logic        ACK;
    logic        ERR;
    logic        t2h_valid;
    logic [31:0] t2h_data;
    logic        t2h_ready = 1'b0;
    logic        h2t_valid = 1'b0;
    logic [31:0] h2t_data = '0;
    logic        h2t_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] base_adr = 32'h6000_1000;
    logic [31:0] h2t_q[$];
    logic [31:0] t2h_q[$];
    rsp_t        exp_q[$];
    rsp_t        mon_e;
    logic        prev_rsp = 1'b0;

    wb_vmon_responder dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ADR       (ADR),
        .DAT_W     (DAT_W),
        .DAT_R     (DAT_R),
        .CYC       (CYC),
        .STB       (STB),
        .WE        (WE),
        .SEL       (SEL),
        .ACK       (ACK),
        .ERR       (ERR),
        .t2h_valid (t2h_valid),
        .t2h_data  (t2h_data),
        .t2h_ready (t2h_ready),
        .h2t_valid (h2t_valid),
        .h2t_data  (h2t_data),
        .h2t_ready (h2t_ready)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model of one resolved access, using the state before the edge.
    task automatic model_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic hpush, input logic [31:0] hdat,
                                output logic hit, output logic stall, output rsp_t r);
        int h_sz;
        int t_sz;
        logic flush;
        logic [31:0] st;
        h_sz  = h2t_q.size();
        t_sz  = t2h_q.size();
        hit   = (adr[31:4] == base_adr[31:4]);
        stall = 1'b0;
        flush = 1'b0;
        r     = '0;
        if (hit) begin
            if (we) begin
                if (sel != 4'hF) r.err = 1'b1;
                else if (adr[3:2] == 2'd0) begin
                    if (t_sz == DEPTH) stall = 1'b1;
                    else begin
                        r.ack = 1'b1;
                        t2h_q.push_back(dat);
                    end
                end else if (adr[3:2] == 2'd3) begin
                    r.ack = 1'b1;
                    flush = dat[0];
                end else r.err = 1'b1;
            end else begin
                r.ack = 1'b1;
                if (adr[3:2] == 2'd1) begin
                    if (h_sz > 0) r.dat = h2t_q.pop_front();
                end else if (adr[3:2] == 2'd2) begin
                    st        = '0;
                    st[0]     = (h_sz > 0);
                    st[1]     = (t_sz == DEPTH);
                    st[11:8]  = 4'(h_sz);
                    st[19:16] = 4'(t_sz);
                    r.dat     = st;
                end
            end
        end
        if (flush) begin
            h2t_q.delete();
            t2h_q.delete();
        end else if (hpush && h_sz < DEPTH) begin
            h2t_q.push_back(hdat);
        end
    endtask

    // Monitor: consumes one expected response per ACK/ERR and watches bus invariants.
    always @(negedge clk_i) begin
        chk("ack_err_exclusive", {31'd0, ACK & ERR}, 32'd0);
        if (!ACK) chk("dat_r_idle_zero", DAT_R, 32'd0);
        if (ACK || ERR) begin
            if (prev_rsp) chk("rsp_single_cycle", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, ACK, ERR}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_ack", {31'd0, ACK}, {31'd0, mon_e.ack});
                chk("rsp_err", {31'd0, ERR}, {31'd0, mon_e.err});
                chk("rsp_dat", DAT_R, mon_e.dat);
            end
        end
        prev_rsp <= ACK | ERR;
    end

    task automatic host_push(input logic [31:0] d);
        @(negedge clk_i);
        chk("h2t_ready", {31'd0, h2t_ready}, {31'd0, (h2t_q.size() < DEPTH)});
        h2t_valid = 1'b1;
        h2t_data  = d;
        if (h2t_q.size() < DEPTH) h2t_q.push_back(d);
        @(negedge clk_i);
        h2t_valid = 1'b0;
    endtask

    task automatic host_pop();
        @(negedge clk_i);
        chk("t2h_valid", {31'd0, t2h_valid}, {31'd0, (t2h_q.size() > 0)});
        if (t2h_q.size() > 0) begin
            chk("t2h_data", t2h_data, t2h_q[0]);
            void'(t2h_q.pop_front());
        end
        t2h_ready = 1'b1;
        @(negedge clk_i);
        t2h_ready = 1'b0;
    endtask

    // One Wishbone access; a stalled TX write is released by a single host pop.
    task automatic wb_do(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic hpush, input logic [31:0] hdat);
        logic hit;
        logic stall;
        logic seen;
        rsp_t r;
        int   n;
        @(negedge clk_i);
        CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_W = dat; SEL = sel;
        h2t_valid = hpush; h2t_data = hdat;
        model_access(we, adr, dat, sel, hpush, hdat, hit, stall, r);
        if (hit && !stall) exp_q.push_back(r);
        @(negedge clk_i);
        h2t_valid = 1'b0;
        if (!hit) begin
            for (int k = 0; k < 3; k++) begin
                chk("miss_no_rsp", {30'd0, ACK, ERR}, 32'd0);
                @(negedge clk_i);
            end
        end else begin
            if (stall) begin
                for (int k = 0; k < 3; k++) begin
                    chk("stall_no_rsp", {30'd0, ACK, ERR}, 32'd0);
                    @(negedge clk_i);
                end
                chk("stall_t2h_head", t2h_data, t2h_q[0]);
                void'(t2h_q.pop_front());
                t2h_ready = 1'b1;
                r = '0;
                r.ack = 1'b1;
                exp_q.push_back(r);
                @(negedge clk_i);
                t2h_ready = 1'b0;
                t2h_q.push_back(dat);
            end
            seen = ACK | ERR;
            n = 0;
            while (!seen && n < 10) begin
                @(negedge clk_i);
                n++;
                seen = ACK | ERR;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL wb_timeout adr=%h no ACK/ERR within 10 cycles", adr);
                void'(exp_q.pop_back());
            end else begin
                chk("rsp_latency", n, stall ? 32'd1 : 32'd0);
            end
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    endtask

    task automatic read_status();
        wb_do(1'b0, base_adr | 32'h8, 32'd0, 4'hF, 1'b0, 32'd0);
    endtask

    task automatic fill_t2h();
        while (t2h_q.size() < DEPTH) wb_do(1'b1, base_adr, $urandom, 4'hF, 1'b0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [1:0]  off;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          r;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("reset_ack", {31'd0, ACK}, 32'd0);
        chk("reset_err", {31'd0, ERR}, 32'd0);
        chk("reset_dat_r", DAT_R, 32'd0);
        chk("reset_t2h_valid", {31'd0, t2h_valid}, 32'd0);
        chk("reset_h2t_ready", {31'd0, h2t_ready}, 32'd1);
        rst_i = 1'b0;

        // Single TX write lands at the t2h head
        wb_do(1'b1, base_adr, 32'h1234_5678, 4'hF, 1'b0, 32'd0);
        @(negedge clk_i);
        chk("tx_t2h_valid", {31'd0, t2h_valid}, 32'd1);
        chk("tx_t2h_data", t2h_data, 32'h1234_5678);
        host_pop();

        // RX reads in order, then empty read returns zero
        host_push(32'hA5);
        host_push(32'h5A);
        repeat (3) wb_do(1'b0, base_adr | 32'h4, 32'd0, 4'hF, 1'b0, 32'd0);
        read_status();

        // Host push and RX read on an empty FIFO at the same edge
        wb_do(1'b0, base_adr | 32'h4, 32'd0, 4'hF, 1'b1, 32'hCAFE_F00D);
        read_status();
        wb_do(1'b0, base_adr | 32'h4, 32'd0, 4'hF, 1'b0, 32'd0);

        // Four TX writes fill t2h; the fifth stalls until one host pop
        for (int i = 0; i < 5; i++) wb_do(1'b1, base_adr, 32'h100 + i, 4'hF, 1'b0, 32'd0);
        read_status();
        repeat (DEPTH) host_pop();

        // Error terminations leave state untouched; misses get no response
        host_push(32'h77);
        wb_do(1'b1, base_adr, 32'h55, 4'hF, 1'b0, 32'd0);
        wb_do(1'b1, base_adr, 32'h66, 4'h3, 1'b0, 32'd0);
        wb_do(1'b1, base_adr | 32'hC, 32'h1, 4'h3, 1'b0, 32'd0);
        wb_do(1'b1, base_adr | 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0);
        wb_do(1'b1, base_adr | 32'h4, 32'h1, 4'hF, 1'b0, 32'd0);
        wb_do(1'b0, 32'h6000_2000, 32'd0, 4'hF, 1'b0, 32'd0);
        wb_do(1'b1, 32'h6000_2000, 32'h9, 4'hF, 1'b0, 32'd0);
        read_status();

        // Flush beats a concurrent host push; CTRL bit0=0 does nothing
        wb_do(1'b1, base_adr | 32'hC, 32'h0, 4'hF, 1'b0, 32'd0);
        read_status();
        wb_do(1'b1, base_adr | 32'hC, 32'h1, 4'hF, 1'b1, 32'h99);
        read_status();

        // Abandoned stall: no push, no response
        fill_t2h();
        @(negedge clk_i);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = base_adr; DAT_W = 32'hDEAD_0001; SEL = 4'hF;
        repeat (2) begin
            @(negedge clk_i);
            chk("abandon_stall_no_rsp", {30'd0, ACK, ERR}, 32'd0);
        end
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("abandon_no_rsp", {30'd0, ACK, ERR}, 32'd0);
        end
        host_pop();
        read_status();

        // Reset while stalled with three h2t entries
        fill_t2h();
        while (h2t_q.size() < 3) host_push($urandom);
        @(negedge clk_i);
        CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = base_adr; DAT_W = 32'hBEEF_0002; SEL = 4'hF;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        CYC = 1'b0; STB = 1'b0; WE = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_stall_ack", {31'd0, ACK}, 32'd0);
        chk("rst_stall_err", {31'd0, ERR}, 32'd0);
        chk("rst_stall_h2t_ready", {31'd0, h2t_ready}, 32'd1);
        chk("rst_stall_t2h_valid", {31'd0, t2h_valid}, 32'd0);
        h2t_q.delete();
        t2h_q.delete();
        read_status();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) host_push($urandom);
            else if (r < 3) host_pop();
            else begin
                we  = 1'($urandom_range(0, 1));
                off = 2'($urandom_range(0, 3));
                adr = base_adr | {28'd0, off, 2'($urandom_range(0, 3))};
                if ($urandom_range(0, 9) == 0) adr = adr ^ (32'd1 << $urandom_range(4, 31));
                sel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                dat = $urandom;
                if (we && off == 2'd3) dat[0] = ($urandom_range(0, 7) == 0);
                wb_do(we, adr, dat, sel, ($urandom_range(0, 3) == 0), $urandom);
            end
        end
        read_status();

        repeat (3) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
